// File: rtl/debug_write_ctrl_if.sv
// debug_write_ctrl_if: single-outstanding req/ack debug write port into the register-file and RAM muxes
interface debug_write_ctrl_if;
  logic        wr_req;
  logic        wr_target;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic [31:0] rd_data;
  modport master (output wr_req, wr_target, wr_addr, wr_data, input wr_ack, rd_data);
  modport slave (input wr_req, wr_target, wr_addr, wr_data, output wr_ack, rd_data);
endinterface

// File: rtl/debug_write_ctrl.sv
// debug_write_ctrl: switch/button hex entry and paused-CPU debug write; DEBUG_WRITE_VERIFY_EN adds a readback check
module debug_write_ctrl #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                      clk_in,
  input  logic                      CLR_n,
  input  logic [15:0]               sw,
  input  logic                      btnu,
  input  logic                      btnc,
  input  logic                      btnd,
  input  logic                      pause,
  debug_write_ctrl_if.master        bus,
  output logic [31:0]               entry_value,
  output logic [3:0]                entry_count,
  output logic                      busy,
  output logic                      err
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ENTRY, REQ, VERIFY, DONE} state_t;
  logic [2:0]         btn;
  logic [2:0]         s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d, prev_q, prev_d, p_q, p_d;
  logic [2:0][CW-1:0] dbc_q, dbc_d;
  logic               u_p, c_p, d_p;
  state_t             state_q, state_d;
  logic [31:0]        val_q, val_d, data_q, data_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         addr_q, addr_d;
  logic [TW-1:0]      to_q, to_d;
  logic               err_q, err_d, req_q, req_d, tgt_q, tgt_d;
  logic               unused_sw;
`ifdef DEBUG_WRITE_VERIFY_EN
  logic               vcnt_q, vcnt_d;
`else
  logic               unused_rd;
  assign unused_rd = ^bus.rd_data;
`endif
  assign unused_sw = ^{sw[15:13], sw[10:8]};
  assign btn = {btnd, btnc, btnu};
  assign {d_p, c_p, u_p} = p_q;
  always_comb begin
    s1_d   = btn;
    s2_d   = s1_q;
    prev_d = lvl_q;
    p_d    = lvl_q & ~prev_q;
    lvl_d  = lvl_q;
    dbc_d  = '0;
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        dbc_d[i] = dbc_q[i] + 1'b1;
        if (dbc_q[i] == CW'(DB_CYCLES - 1)) begin
          lvl_d[i] = s2_q[i];
          dbc_d[i] = '0;
        end
      end
    end
  end
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    req_d   = req_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    to_d    = '0;
`ifdef DEBUG_WRITE_VERIFY_EN
    vcnt_d  = 1'b0;
`endif
    case (state_q)
      IDLE: if (u_p) begin
        val_d   = {28'd0, sw[3:0]};
        cnt_d   = 4'd1;
        err_d   = 1'b0;
        state_d = ENTRY;
      end
      ENTRY: if (d_p) begin
        val_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else if (c_p) begin
        if (!pause || !(sw[12] ^ sw[11])) err_d = 1'b1;
        else begin
          tgt_d   = sw[11];
          addr_d  = sw[11] ? {sw[7:2], 2'b00} : {3'b000, sw[4:0]};
          data_d  = val_q;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end else if (u_p) begin
        val_d = {val_q[27:0], sw[3:0]};
        cnt_d = (cnt_q == 4'd8) ? cnt_q : cnt_q + 4'd1;
      end
      REQ: if (bus.wr_ack) begin
        req_d = 1'b0;
`ifdef DEBUG_WRITE_VERIFY_EN
        state_d = VERIFY;
`else
        state_d = DONE;
`endif
      end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
        req_d   = 1'b0;
        err_d   = 1'b1;
        state_d = ENTRY;
      end else to_d = to_q + 1'b1;
      VERIFY: begin
`ifdef DEBUG_WRITE_VERIFY_EN
        if (!vcnt_q) vcnt_d = 1'b1;
        else if (bus.rd_data == data_q) state_d = DONE;
        else begin
          err_d   = 1'b1;
          state_d = ENTRY;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge CLR_n) begin
    if (!CLR_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      prev_q  <= '0;
      p_q     <= '0;
      dbc_q   <= '0;
      state_q <= IDLE;
      val_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      tgt_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      to_q    <= '0;
`ifdef DEBUG_WRITE_VERIFY_EN
      vcnt_q  <= 1'b0;
`endif
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      lvl_q   <= lvl_d;
      prev_q  <= prev_d;
      p_q     <= p_d;
      dbc_q   <= dbc_d;
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      req_q   <= req_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      to_q    <= to_d;
`ifdef DEBUG_WRITE_VERIFY_EN
      vcnt_q  <= vcnt_d;
`endif
    end
  end
  assign bus.wr_req    = req_q;
  assign bus.wr_target = tgt_q;
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = data_q;
  assign entry_value   = val_q;
  assign entry_count   = cnt_q;
  assign err           = err_q;
  assign busy          = (state_q == REQ) || (state_q == VERIFY);
endmodule

// File: tb/tb_debug_write_ctrl.sv
// tb_debug_write_ctrl: directed and randomized checks of debug_write_ctrl against a behavioural entry/commit model
module tb_debug_write_ctrl;
  localparam int DB = 4;
  localparam int AT = 8;
  logic        clk_in = 1'b0;
  logic        CLR_n = 1'b0;
  logic [15:0] sw = '0;
  logic        btnu = 1'b0, btnc = 1'b0, btnd = 1'b0, pause = 1'b0;
  logic [31:0] entry_value;
  logic [3:0]  entry_count;
  logic        busy, err;
  int          checks = 0, failures = 0;
  logic [31:0] m_val = '0;
  int          m_cnt = 0;
  logic        m_err = 1'b0;
  bit          m_entry = 1'b0;
  debug_write_ctrl_if bus();
  debug_write_ctrl #(.DB_CYCLES(DB), .ACK_TIMEOUT(AT)) dut (
    .clk_in(clk_in), .CLR_n(CLR_n), .sw(sw), .btnu(btnu), .btnc(btnc), .btnd(btnd),
    .pause(pause), .bus(bus), .entry_value(entry_value), .entry_count(entry_count),
    .busy(busy), .err(err)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic check_model(input string tag);
    check({tag, "_val"}, entry_value, m_val);
    check({tag, "_cnt"}, 32'(entry_count), 32'(m_cnt));
    check({tag, "_err"}, 32'(err), 32'(m_err));
    check({tag, "_req"}, 32'(bus.wr_req), 32'd0);
  endtask
  task automatic digit(input logic [3:0] d);
    sw[3:0] = d;
    btnu = 1'b1;
    tick(DB + 6);
    btnu = 1'b0;
    tick(DB + 6);
    if (!m_entry) begin
      m_val = {28'd0, d};
      m_cnt = 1;
      m_err = 1'b0;
      m_entry = 1'b1;
    end else begin
      m_val = (m_val << 4) | {28'd0, d};
      if (m_cnt < 8) m_cnt++;
    end
    check_model("digit");
  endtask
  task automatic clear_entry();
    btnd = 1'b1;
    tick(DB + 6);
    btnd = 1'b0;
    tick(DB + 6);
    if (m_entry) begin
      m_val = '0;
      m_cnt = 0;
      m_entry = 1'b0;
    end
    check_model("clear");
  endtask
  task automatic commit(input bit p, input logic [1:0] rg, input logic [7:0] a, input int ack_delay);
    bit ok;
    logic [7:0] exp_addr;
    ok = p && (rg == 2'b01 || rg == 2'b10);
    exp_addr = rg[0] ? (a & 8'hFC) : (a & 8'h1F);
    pause = p;
    sw[12:11] = rg;
    sw[7:0] = a;
    btnc = 1'b1;
    tick(DB + 4);
    if (!ok) begin
      m_err = 1'b1;
      check_model("bad_commit");
      check("bad_commit_busy", 32'(busy), 32'd0);
    end else begin
      check("req_up", 32'(bus.wr_req), 32'd1);
      check("req_busy", 32'(busy), 32'd1);
      check("req_target", 32'(bus.wr_target), 32'(rg[0]));
      check("req_addr", 32'(bus.wr_addr), 32'(exp_addr));
      check("req_data", bus.wr_data, m_val);
      if (ack_delay >= 0) begin
        for (int i = 0; i < ack_delay; i++) begin
          tick(1);
          pause = 1'($urandom);
          check("req_hold", 32'(bus.wr_req), 32'd1);
          check("req_hold_data", bus.wr_data, m_val);
        end
        bus.wr_ack = 1'b1;
        tick(1);
        bus.wr_ack = 1'b0;
        check("ack_drop", 32'(bus.wr_req), 32'd0);
        tick(1);
        m_cnt = 0;
        m_entry = 1'b0;
        check_model("done");
        check("done_busy", 32'(busy), 32'd0);
      end else begin
        for (int i = 0; i < AT - 1; i++) begin
          tick(1);
          check("to_hold", 32'(bus.wr_req), 32'd1);
        end
        tick(1);
        m_err = 1'b1;
        check_model("timeout");
        check("timeout_busy", 32'(busy), 32'd0);
      end
    end
    btnc = 1'b0;
    tick(DB + 6);
  endtask
  initial begin
    bus.wr_ack = 1'b0;
    bus.rd_data = '0;
    tick(2);
    check("rst_val", entry_value, 32'd0);
    check("rst_cnt", 32'(entry_count), 32'd0);
    check("rst_req", 32'(bus.wr_req), 32'd0);
    check("rst_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_data", bus.wr_data, 32'd0);
    check("rst_tgt", 32'(bus.wr_target), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    CLR_n = 1'b1;
    tick(2);
    sw[3:0] = 4'hA;
    btnu = 1'b1;
    tick(DB + 3);
    check("lat_before", entry_value, 32'd0);
    tick(1);
    check("lat_after", entry_value, 32'h0000000A);
    tick(2);
    btnu = 1'b0;
    tick(DB + 6);
    m_val = 32'hA;
    m_cnt = 1;
    m_entry = 1'b1;
    check_model("first");
    sw[3:0] = 4'h3;
    btnu = 1'b1;
    tick(2);
    btnu = 1'b0;
    tick(DB + 8);
    check_model("glitch");
    digit(4'h5);
    digit(4'hF);
    check("a5f_val", entry_value, 32'h00000A5F);
    check("a5f_cnt", 32'(entry_count), 32'd3);
    bus.wr_ack = 1'b1;
    tick(1);
    bus.wr_ack = 1'b0;
    tick(1);
    check_model("stray_ack");
    clear_entry();
    for (int i = 1; i <= 9; i++) digit(4'(i));
    check("nine_val", entry_value, 32'h23456789);
    check("nine_cnt", 32'(entry_count), 32'd8);
    clear_entry();
    begin
      logic [31:0] dbf;
      dbf = 32'hDEADBEEF;
      for (int i = 7; i >= 0; i--) digit(dbf[i*4 +: 4]);
    end
    check("dbf_val", entry_value, 32'hDEADBEEF);
    commit(1'b1, 2'b01, 8'h17, 3);
    digit(4'h1);
    commit(1'b0, 2'b01, 8'h17, 0);
    commit(1'b1, 2'b11, 8'h17, 0);
    digit(4'h2);
    check("bad_keep_err", 32'(err), 32'd1);
    commit(1'b1, 2'b10, 8'h4C, -1);
    check("to_retained", entry_value, 32'h00000012);
    sw[12:11] = 2'b01;
    pause = 1'b1;
    btnc = 1'b1;
    btnd = 1'b1;
    tick(DB + 4);
    m_val = '0;
    m_cnt = 0;
    m_entry = 1'b0;
    check_model("dc_same");
    tick(3);
    check("dc_no_req", 32'(bus.wr_req), 32'd0);
    btnc = 1'b0;
    btnd = 1'b0;
    tick(DB + 6);
    digit(4'h7);
    digit(4'h8);
    btnc = 1'b1;
    tick(DB + 4);
    check("rst_mid_req_up", 32'(bus.wr_req), 32'd1);
    #2 CLR_n = 1'b0;
    #1 check("rst_mid_req", 32'(bus.wr_req), 32'd0);
    check("rst_mid_val", entry_value, 32'd0);
    btnc = 1'b0;
    tick(2);
    CLR_n = 1'b1;
    tick(DB + 6);
    m_val = '0;
    m_cnt = 0;
    m_err = 1'b0;
    m_entry = 1'b0;
    check_model("after_rst");
    for (int r = 0; r < 8; r++) begin
      int n;
      int dly;
      if (m_entry && ($urandom_range(0, 2) == 0)) clear_entry();
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) digit(4'($urandom));
      dly = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 5);
      commit(($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), dly);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
